// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_arb_pkg;

   // Which requester currently holds priority.
   typedef enum logic [0:0] {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_state_e;

   // W_Src debug tag encodings.
   localparam logic [1:0] SRC_IDLE = 2'b00;
   localparam logic [1:0] SRC_A    = 2'b01;
   localparam logic [1:0] SRC_B    = 2'b10;

   // Default register address and data widths.
   localparam int DEF_ADDR = 5;
   localparam int DEF_SIZE = 32;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of both writeback request channels plus the registered write port.
// Latency: n/a (wiring only).
// Backpressure: A_Ready/B_Ready flow from slave (arbiter) to master (requesters).
interface regfile_wr_arbiter_if
   import regfile_arb_pkg::*;
#(
   parameter int ADDR = DEF_ADDR,
   parameter int SIZE = DEF_SIZE
);
   logic            A_Valid;
   logic            A_Ready;
   logic [ADDR-1:0] A_Addr;
   logic [SIZE-1:0] A_Data;

   logic            B_Valid;
   logic            B_Ready;
   logic [ADDR-1:0] B_Addr;
   logic [SIZE-1:0] B_Data;

   logic [ADDR-1:0] W_Addr;
   logic [SIZE-1:0] W_Data;
   logic [1:0]      W_Src;

   // Requester / environment side.
   modport master (
      output A_Valid, A_Addr, A_Data,
      output B_Valid, B_Addr, B_Data,
      input  A_Ready, B_Ready,
      input  W_Addr, W_Data, W_Src
   );

   // Arbiter side.
   modport slave (
      input  A_Valid, A_Addr, A_Data,
      input  B_Valid, B_Addr, B_Data,
      output A_Ready, B_Ready,
      output W_Addr, W_Data, W_Src
   );

endinterface

// File: rtl/regfile_wr_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles requester B has lost arbitration.
// Latency: at_max is combinational from the post-update count.
// Backpressure: none; inc/clr are sampled every cycle.
module arb_starve_ctr #(
   parameter int STARVE_MAX = 3
) (
   input  logic Clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_max
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_upd;

   // Post-update value: clear wins, otherwise count up and saturate at the limit.
   always_comb begin
      cnt_upd = cnt;
      if (clr) begin
         cnt_upd = '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt_upd = cnt + CW'(1);
      end
   end

   assign at_max = (cnt_upd == CNT_MAX);

   // Reaching the limit promotes B on the same edge, which is itself a clearing
   // transition, so the stored count returns to zero there.
   always_ff @(posedge Clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (at_max) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_upd;
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the single register-file write port, A priority with B anti-starvation.
// Latency: request accepted at edge t appears on W_Addr/W_Data during cycle t+1.
// Backpressure: combinational A_Ready/B_Ready from the grant; at most one high per cycle.
module regfile_wr_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int ADDR       = DEF_ADDR,
   parameter int SIZE       = DEF_SIZE,
   parameter int STARVE_MAX = 3
) (
   input  logic                  Clk,
   input  logic                  reset,
   regfile_wr_arbiter_if.slave   wr
);
   prio_state_e     state;
   prio_state_e     state_nxt;
   prio_state_e     eff_state;
   logic            grant_a;
   logic            grant_b;
   logic            promote_b;
   logic [ADDR-1:0] w_addr_nxt;
   logic [SIZE-1:0] w_data_nxt;
   logic [1:0]      w_src_nxt;

   // While reset is held the readies behave as in PRIO_A, whatever the register holds.
   assign eff_state = reset ? PRIO_A : state;

   // Grant selection for the current priority state.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (eff_state == PRIO_A) begin
         if (wr.A_Valid)      grant_a = 1'b1;
         else if (wr.B_Valid) grant_b = 1'b1;
      end else begin
         if (wr.B_Valid)      grant_b = 1'b1;
         else if (wr.A_Valid) grant_a = 1'b1;
      end
   end

   // When nobody is valid the idle ready goes to A only, so the two readies
   // are never high together.
   assign wr.A_Ready = grant_a | ~wr.B_Valid;
   assign wr.B_Ready = grant_b;

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .Clk    (Clk),
      .reset  (reset),
      .inc    (wr.B_Valid & ~grant_b),
      .clr    (~wr.B_Valid | grant_b),
      .at_max (promote_b)
   );

   // Priority FSM: B is promoted after enough losses, and gives priority back
   // after its grant or when it stops requesting.
   always_comb begin
      state_nxt = state;
      case (state)
         PRIO_A:  if (promote_b) state_nxt = PRIO_B;
         PRIO_B:  if (grant_b || !wr.B_Valid) state_nxt = PRIO_A;
         default: state_nxt = PRIO_A;
      endcase
   end

   // Priority state register.
   always_ff @(posedge Clk) begin
      if (reset) state <= PRIO_A;
      else       state <= state_nxt;
   end

   // Next write-port contents; address 0 naturally produces a discarded write.
   always_comb begin
      w_addr_nxt = '0;
      w_data_nxt = wr.W_Data;
      w_src_nxt  = SRC_IDLE;
      if (grant_a) begin
         w_addr_nxt = wr.A_Addr;
         w_data_nxt = wr.A_Data;
         w_src_nxt  = SRC_A;
      end else if (grant_b) begin
         w_addr_nxt = wr.B_Addr;
         w_data_nxt = wr.B_Data;
         w_src_nxt  = SRC_B;
      end
   end

   // Registered write port so the register file sees one clean write per cycle.
   always_ff @(posedge Clk) begin
      if (reset) begin
         wr.W_Addr <= '0;
         wr.W_Data <= '0;
         wr.W_Src  <= SRC_IDLE;
      end else begin
         wr.W_Addr <= w_addr_nxt;
         wr.W_Data <= w_data_nxt;
         wr.W_Src  <= w_src_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a small register-file sink model.
// Latency: checks W_* one cycle after acceptance, register contents one cycle later.
// Backpressure: requesters hold payload while Valid && !Ready.
module tb_regfile_wr_arbiter;
   import regfile_arb_pkg::*;

   logic Clk;
   logic reset;
   int   chk_cnt;
   int   err_cnt;
   logic [31:0] rf [0:31];

   regfile_wr_arbiter_if #(.ADDR(5), .SIZE(32)) wr ();

   regfile_wr_arbiter #(
      .ADDR       (5),
      .SIZE       (32),
      .STARVE_MAX (3)
   ) dut (
      .Clk   (Clk),
      .reset (reset),
      .wr    (wr.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Register-file sink: captures the write port, shares the arbiter's reset.
   always @(posedge Clk) begin
      if (!reset && wr.W_Addr != 5'd0) rf[wr.W_Addr] <= wr.W_Data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
      wr.A_Valid = av; wr.A_Addr = aa; wr.A_Data = ad;
      wr.B_Valid = bv; wr.B_Addr = ba; wr.B_Data = bd;
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic smp();
      @(negedge Clk);
   endtask

   initial begin
      logic [7:0] exp_b8;
      logic [6:0] bv7;
      logic [6:0] exp_b7;
      logic [2:0] exp_b3;
      chk_cnt = 0;
      err_cnt = 0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);

      // Reset state.
      cyc(); cyc();
      smp();
      chk("rst_a_rdy", 32'(wr.A_Ready), 32'd1);
      chk("rst_b_rdy", 32'(wr.B_Ready), 32'd0);
      chk("rst_waddr", 32'(wr.W_Addr), 32'd0);
      chk("rst_wdata", wr.W_Data, 32'd0);
      chk("rst_wsrc", 32'(wr.W_Src), 32'(SRC_IDLE));

      // A alone.
      cyc(); reset = 1'b0;
      drive(1, 5'd5, 32'h1234, 0, 0, 0);
      smp();
      chk("a_only_a_rdy", 32'(wr.A_Ready), 32'd1);
      chk("a_only_b_rdy", 32'(wr.B_Ready), 32'd0);
      cyc(); drive(0, 0, 0, 0, 0, 0);
      smp();
      chk("a_only_waddr", 32'(wr.W_Addr), 32'd5);
      chk("a_only_wdata", wr.W_Data, 32'h1234);
      chk("a_only_wsrc", 32'(wr.W_Src), 32'(SRC_A));
      cyc();
      smp();
      chk("idle_waddr", 32'(wr.W_Addr), 32'd0);
      chk("idle_wsrc", 32'(wr.W_Src), 32'(SRC_IDLE));
      chk("idle_wdata_hold", wr.W_Data, 32'h1234);
      chk("rf5", rf[5], 32'h1234);

      // Both continuously valid: B wins on cycles 4 and 8.
      exp_b8 = 8'b1000_1000;
      for (int i = 0; i < 8; i++) begin
         cyc();
         drive(1, 5'd1, 32'h100 + 32'(i), 1, 5'd2, 32'h200 + 32'(i));
         smp();
         chk($sformatf("both_b_rdy%0d", i), 32'(wr.B_Ready), 32'(exp_b8[i]));
         chk($sformatf("both_a_rdy%0d", i), 32'(wr.A_Ready), 32'(!exp_b8[i]));
      end
      cyc(); drive(0, 0, 0, 0, 0, 0);
      smp();
      chk("both_last_wsrc", 32'(wr.W_Src), 32'(SRC_B));
      chk("both_last_wdata", wr.W_Data, 32'h207);

      // B alone with address 0: handshake completes, no write.
      cyc(); drive(0, 0, 0, 1, 5'd0, 32'hDEAD);
      smp();
      chk("b0_b_rdy", 32'(wr.B_Ready), 32'd1);
      chk("b0_a_rdy", 32'(wr.A_Ready), 32'd0);
      cyc(); drive(0, 0, 0, 0, 0, 0);
      smp();
      chk("b0_waddr", 32'(wr.W_Addr), 32'd0);
      chk("b0_wsrc", 32'(wr.W_Src), 32'(SRC_B));
      cyc();
      smp();
      chk("rf2", rf[2], 32'h207);
      chk("rf1", rf[1], 32'h106);

      // Same destination from both sides: A first, then B; B data persists.
      cyc(); drive(1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB);
      smp();
      chk("same_a_rdy", 32'(wr.A_Ready), 32'd1);
      chk("same_b_rdy0", 32'(wr.B_Ready), 32'd0);
      cyc(); drive(0, 0, 0, 1, 5'd7, 32'hBBBB);
      smp();
      chk("same_b_rdy1", 32'(wr.B_Ready), 32'd1);
      chk("same_w1_addr", 32'(wr.W_Addr), 32'd7);
      chk("same_w1_data", wr.W_Data, 32'hAAAA);
      cyc(); drive(0, 0, 0, 0, 0, 0);
      smp();
      chk("same_w2_addr", 32'(wr.W_Addr), 32'd7);
      chk("same_w2_data", wr.W_Data, 32'hBBBB);
      chk("same_w2_src", 32'(wr.W_Src), 32'(SRC_B));
      cyc();
      smp();
      chk("rf7", rf[7], 32'hBBBB);

      // B waits 2, drops for a cycle, then needs 3 fresh losses.
      bv7    = 7'b1111011;
      exp_b7 = 7'b1000000;
      for (int i = 0; i < 7; i++) begin
         cyc();
         drive(1, 5'd3, 32'h300 + 32'(i), bv7[i], 5'd4, 32'h4444);
         smp();
         chk($sformatf("starve_b_rdy%0d", i), 32'(wr.B_Ready), 32'(exp_b7[i]));
         chk($sformatf("starve_a_rdy%0d", i), 32'(wr.A_Ready), 32'(!exp_b7[i]));
      end

      // Drive the FSM into PRIO_B, then reset while A's write to r9 is registered.
      cyc(); drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (i == 2) drive(1, 5'd9, 32'h9999, 1, 5'd6, 32'h6666);
         else        drive(1, 5'd4, 32'h4444, 1, 5'd6, 32'h6666);
         smp();
         chk($sformatf("pre_rst_a_rdy%0d", i), 32'(wr.A_Ready), 32'd1);
      end
      cyc(); reset = 1'b1;
      smp();
      chk("mid_rst_a_rdy", 32'(wr.A_Ready), 32'd1);
      chk("mid_rst_b_rdy", 32'(wr.B_Ready), 32'd0);
      chk("mid_rst_waddr9", 32'(wr.W_Addr), 32'd9);
      cyc(); reset = 1'b0;
      drive(1, 5'd10, 32'hA0, 1, 5'd6, 32'h6666);
      smp();
      chk("post_rst_waddr", 32'(wr.W_Addr), 32'd0);
      chk("post_rst_wsrc", 32'(wr.W_Src), 32'(SRC_IDLE));
      chk("post_rst_wdata", wr.W_Data, 32'd0);
      chk("post_rst_a_rdy", 32'(wr.A_Ready), 32'd1);
      chk("post_rst_b_rdy", 32'(wr.B_Ready), 32'd0);
      chk("rf9", rf[9], 32'd0);
      exp_b3 = 3'b100;
      for (int i = 0; i < 3; i++) begin
         cyc();
         smp();
         chk($sformatf("post_rst_b_rdy%0d", i), 32'(wr.B_Ready), 32'(exp_b3[i]));
      end

      cyc(); drive(0, 0, 0, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
